// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the branch predictor slice.
package branch_predictor_pkg;

   // 2-bit saturating counter states; the MSB is the taken prediction
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      STR = 2'b11
   } bp_cnt_e;

   localparam int BP_ENTRIES = 16;
   localparam int BP_STAT_W  = 32;
   localparam int BP_PC_INC  = 4;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and branch-resolution bus between the core and the predictor.
interface branch_predictor_if #(
   parameter int XLEN = 32
) ();
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic            pred_hit;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;

   logic            rs_valid;
   logic [XLEN-1:0] rs_pc;
   logic            rs_is_branch;
   logic            rs_taken;
   logic [XLEN-1:0] rs_target;
   logic            rs_pred_taken;
   logic [XLEN-1:0] rs_pred_target;
   logic            mispredict;
   logic [XLEN-1:0] redirect_pc;

   // core side
   modport master (
      output if_valid, if_pc,
      output rs_valid, rs_pc, rs_is_branch, rs_taken, rs_target,
      output rs_pred_taken, rs_pred_target,
      input  pred_hit, pred_taken, pred_target,
      input  mispredict, redirect_pc
   );

   // predictor side
   modport slave (
      input  if_valid, if_pc,
      input  rs_valid, rs_pc, rs_is_branch, rs_taken, rs_target,
      input  rs_pred_taken, rs_pred_target,
      output pred_hit, pred_taken, pred_target,
      output mispredict, redirect_pc
   );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state function (combinational only).
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       inc,
   output logic [1:0] nxt
);

   // step toward taken on inc, toward not-taken otherwise, clamp at the ends
   always_comb begin
      nxt = cnt;
      if (inc) begin
         if (cnt != STR) nxt = cnt + 2'd1;
      end else begin
         if (cnt != SNT) nxt = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency IF lookup,
// same-cycle mispredict/redirect at resolution, training on the next edge.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = BP_ENTRIES,
   parameter int STAT_W  = BP_STAT_W
) (
   input  logic              clk,
   input  logic              rst,
   branch_predictor_if.slave bus,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [XLEN-1:0] INC = XLEN'(BP_PC_INC);

   logic [ENTRIES-1:0] vld_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [XLEN-1:0]    tgt_q [ENTRIES];
   logic [1:0]         cnt_q [ENTRIES];

   logic [IDX_W-1:0] lk_idx, rs_idx;
   logic [TAG_W-1:0] lk_tag, rs_tag;
   logic             lk_hit, rs_hit, misp;
   logic [1:0]       cnt_nxt;

   assign lk_idx = bus.if_pc[IDX_W+1:2];
   assign lk_tag = bus.if_pc[XLEN-1:IDX_W+2];
   assign rs_idx = bus.rs_pc[IDX_W+1:2];
   assign rs_tag = bus.rs_pc[XLEN-1:IDX_W+2];

   assign lk_hit = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign rs_hit = vld_q[rs_idx] && (tag_q[rs_idx] == rs_tag);

   // IF lookup reads registered state only, so a same-cycle write is not visible
   always_comb begin
      bus.pred_hit    = bus.if_valid && lk_hit;
      bus.pred_taken  = bus.if_valid && lk_hit && cnt_q[lk_idx][1];
      bus.pred_target = bus.pred_taken ? tgt_q[lk_idx] : bus.if_pc + INC;
   end

   // resolution check: wrong direction, wrong taken target, or aliased hit on a non-branch
   always_comb begin
      misp = 1'b0;
      if (bus.rs_valid) begin
         if (bus.rs_is_branch)
            misp = (bus.rs_taken != bus.rs_pred_taken) ||
                   (bus.rs_taken && (bus.rs_target != bus.rs_pred_target));
         else
            misp = bus.rs_pred_taken;
      end
   end

   // redirect outputs are held at zero while in reset or idle
   always_comb begin
      bus.mispredict  = misp && !rst;
      bus.redirect_pc = '0;
      if (bus.rs_valid && !rst)
         bus.redirect_pc = (bus.rs_is_branch && bus.rs_taken) ? bus.rs_target
                                                              : bus.rs_pc + INC;
   end

   bp_sat_counter u_sat (
      .cnt (cnt_q[rs_idx]),
      .inc (bus.rs_taken),
      .nxt (cnt_nxt)
   );

   // table training: one write per cycle at the resolving index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            cnt_q[i] <= WNT;
         end
      end else if (bus.rs_valid) begin
         if (bus.rs_is_branch) begin
            if (rs_hit) begin
               cnt_q[rs_idx] <= cnt_nxt;
               if (bus.rs_taken) tgt_q[rs_idx] <= bus.rs_target;
            end else if (bus.rs_taken) begin
               vld_q[rs_idx] <= 1'b1;
               tag_q[rs_idx] <= rs_tag;
               tgt_q[rs_idx] <= bus.rs_target;
               cnt_q[rs_idx] <= WT;
            end
         end else if (rs_hit) begin
            vld_q[rs_idx] <= 1'b0;
         end
      end
   end

   // saturating statistics, never wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (bus.rs_valid && bus.rs_is_branch && (stat_branches != '1))
            stat_branches <= stat_branches + STAT_W'(1);
         if (misp && (stat_mispredicts != '1))
            stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: driver pushes expectations from a table model, monitor
// compares at the falling edge.
module tb_branch_predictor;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 16;
   localparam int STAT_W  = 6;
   localparam int IDX_W   = $clog2(ENTRIES);
   localparam int SMAX    = (1 << STAT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [STAT_W-1:0] stat_branches, stat_mispredicts;

   branch_predictor_if #(.XLEN(XLEN)) bus ();

   branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   // reference model: table of entries with an integer counter 0..3
   typedef struct {
      bit          v;
      logic [31:0] tag;
      logic [31:0] tgt;
      int          cnt;
   } ent_t;

   typedef struct {
      bit          v;
      logic [31:0] pc;
      bit          br;
      bit          tk;
      logic [31:0] tgt;
      bit          misp;
   } pend_t;

   typedef struct {
      logic        hit;
      logic        taken;
      logic [31:0] target;
      logic        misp;
      logic [31:0] redir;
      int          sb;
      int          sm;
   } exp_t;

   ent_t  tbl [ENTRIES];
   pend_t pend;
   int    m_sb, m_sm;
   exp_t  exq [$];
   int    nchk = 0;
   int    nerr = 0;

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic logic [31:0] tag_of(logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      return tbl[idx_of(pc)].v && (tbl[idx_of(pc)].tag == tag_of(pc));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) tbl[i] = '{1'b0, 32'h0, 32'h0, 1};
      m_sb = 0;
      m_sm = 0;
      pend.v = 1'b0;
   endtask

   task automatic model_update();
      int i;
      bit h;
      i = idx_of(pend.pc);
      h = m_hit(pend.pc);
      if (pend.br) begin
         if (h) begin
            if (pend.tk) begin
               tbl[i].cnt = (tbl[i].cnt < 3) ? tbl[i].cnt + 1 : 3;
               tbl[i].tgt = pend.tgt;
            end else begin
               tbl[i].cnt = (tbl[i].cnt > 0) ? tbl[i].cnt - 1 : 0;
            end
         end else if (pend.tk) begin
            tbl[i] = '{1'b1, tag_of(pend.pc), pend.tgt, 2};
         end
         if (m_sb < SMAX) m_sb++;
      end else if (h) begin
         tbl[i].v = 1'b0;
      end
      if (pend.misp && m_sm < SMAX) m_sm++;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // r: 0 = run, 1 = hold reset over the whole cycle, 2 = assert reset mid-cycle
   task automatic step(int r, bit ifv, logic [31:0] ifpc, bit rsv, logic [31:0] rpc,
                       bit br, bit tk, logic [31:0] tgt, bit ptk, logic [31:0] ptgt);
      exp_t e;
      @(posedge clk);
      if (!rst && pend.v) model_update();
      pend.v = 1'b0;
      #1;
      if (r == 1) begin
         rst = 1'b1;
         model_reset();
      end else begin
         rst = 1'b0;
      end
      bus.if_valid       = ifv;
      bus.if_pc          = ifpc;
      bus.rs_valid       = rsv;
      bus.rs_pc          = rpc;
      bus.rs_is_branch   = br;
      bus.rs_taken       = tk;
      bus.rs_target      = tgt;
      bus.rs_pred_taken  = ptk;
      bus.rs_pred_target = ptgt;
      if (r == 2) begin
         #2;
         rst = 1'b1;
         model_reset();
      end
      e.hit    = ifv && m_hit(ifpc);
      e.taken  = e.hit && (tbl[idx_of(ifpc)].cnt >= 2);
      e.target = e.taken ? tbl[idx_of(ifpc)].tgt : ifpc + 32'd4;
      e.misp   = rsv && (br ? ((tk != ptk) || (tk && tgt != ptgt)) : ptk);
      e.redir  = rsv ? ((br && tk) ? tgt : rpc + 32'd4) : 32'h0;
      e.sb     = m_sb;
      e.sm     = m_sm;
      if (r == 0) pend = '{rsv, rpc, br, tk, tgt, e.misp};
      if (rst) begin
         e.misp  = 1'b0;
         e.redir = 32'h0;
      end
      exq.push_back(e);
   endtask

   task automatic look(logic [31:0] pc);
      step(0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic resolve(logic [31:0] pc, bit br, bit tk, logic [31:0] tgt,
                          bit ptk, logic [31:0] ptgt);
      step(0, 1'b1, pc, 1'b1, pc, br, tk, tgt, ptk, ptgt);
   endtask

   function automatic logic [31:0] rand_pc();
      case ($urandom_range(0, 7))
         0: return 32'h100;
         1: return 32'h140;
         2: return 32'h180;
         3: return 32'h104;
         4: return 32'h1c0;
         5: return 32'h202;
         default: return $urandom_range(0, 32'h3ff);
      endcase
   endfunction

   function automatic logic [31:0] rand_tgt();
      case ($urandom_range(0, 3))
         0: return 32'h80;
         1: return 32'h300;
         default: return $urandom_range(0, 32'hfff) & 32'hffc;
      endcase
   endfunction

   // monitor: outputs are combinational, so every cycle carries one response
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exq.size() > 0) begin
            e = exq.pop_front();
            chk("pred_hit",         32'(bus.pred_hit),      32'(e.hit));
            chk("pred_taken",       32'(bus.pred_taken),    32'(e.taken));
            chk("pred_target",      bus.pred_target,        e.target);
            chk("mispredict",       32'(bus.mispredict),    32'(e.misp));
            chk("redirect_pc",      bus.redirect_pc,        e.redir);
            chk("stat_branches",    32'(stat_branches),     32'(e.sb));
            chk("stat_mispredicts", 32'(stat_mispredicts),  32'(e.sm));
         end
      end
   end

   initial begin
      logic [31:0] pc, ptgt;
      bit ptk, br, tk;
      model_reset();
      bus.if_valid = 1'b0; bus.if_pc = '0; bus.rs_valid = 1'b0; bus.rs_pc = '0;
      bus.rs_is_branch = 1'b0; bus.rs_taken = 1'b0; bus.rs_target = '0;
      bus.rs_pred_taken = 1'b0; bus.rs_pred_target = '0;

      // reset, then a cold lookup
      step(1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      look(32'h100);
      // first taken resolution allocates
      resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
      look(32'h100);
      // saturate, then one not-taken keeps prediction taken
      repeat (3) resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
      resolve(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
      look(32'h100);
      // aliased non-branch invalidates
      resolve(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
      look(32'h100);
      // same index, different tag replaces
      resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
      resolve(32'h140, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
      look(32'h100);
      look(32'h140);
      // same-cycle update and lookup sees old contents
      resolve(32'h140, 1'b1, 1'b0, 32'h300, 1'b1, 32'h300);
      look(32'h140);
      // async reset mid-cycle with a resolution in flight
      step(2, 1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
      look(32'h140);

      // randomized traffic; statistics saturate along the way
      for (int n = 0; n < 900; n++) begin
         pc = rand_pc();
         br = ($urandom_range(0, 3) != 0);
         tk = $urandom_range(0, 1);
         if ($urandom_range(0, 9) < 7) begin
            ptk  = m_hit(pc) && (tbl[idx_of(pc)].cnt >= 2);
            ptgt = ptk ? tbl[idx_of(pc)].tgt : pc + 32'd4;
         end else begin
            ptk  = $urandom_range(0, 1);
            ptgt = rand_tgt();
         end
         step(($urandom_range(0, 199) == 0) ? 2 : 0,
              $urandom_range(0, 3) != 0, rand_pc(),
              $urandom_range(0, 9) < 6, pc, br, tk, rand_tgt(), ptk, ptgt);
      end
      // a few guaranteed mispredicts on top of saturated statistics
      repeat (3) resolve(32'h180, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
      look(32'h180);

      @(negedge clk);
      @(negedge clk);
      nchk++;
      if (exq.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exq.size());
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Dynamic branch predictor for the 5-stage core. It pairs a direct-mapped branch target buffer with per-entry 2-bit saturating counters.
- IF stage: looks up the fetch PC combinationally to produce a predicted next PC.
- Branch-resolution point (ID): receives the resolved outcome, raises mispredict/redirect, and trains the table on the next clock edge.
- Also keeps saturating branch and mispredict statistics counters.

Parameters:
XLEN, 32, data/address width.
ENTRIES, 16, BTB entries; power of two, at least 2. IDX_W = log2(ENTRIES).
STAT_W, 32, width of the statistics counters.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  asynchronous, active-high reset.
if_valid  input  1  fetch lookup valid.
if_pc  input  XLEN  fetch PC.
pred_hit  output  1  valid tag match for if_pc.
pred_taken  output  1  pred_hit and counter MSB = 1.
pred_target  output  XLEN  stored target when pred_taken, else if_pc+4.
rs_valid  input  1  resolution valid (instruction in ID not stalled or flushed).
rs_pc  input  XLEN  PC of the resolving instruction.
rs_is_branch  input  1  instruction is a conditional branch.
rs_taken  input  1  actual outcome.
rs_target  input  XLEN  actual target (pc+imm).
rs_pred_taken  input  1  prediction carried down the pipe.
rs_pred_target  input  XLEN  predicted target carried down the pipe.
mispredict  output  1  flush IF/ID and redirect the PC.
redirect_pc  output  XLEN  correct next PC.
stat_branches  output  STAT_W  resolved branches.
stat_mispredicts  output  STAT_W  mispredicts.

Behaviour:
- Indexing: index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Entry storage: valid, tag, target, cnt[1:0].
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup: purely combinational, zero latency. if_valid=0 forces pred_hit=0 and pred_taken=0.
- Read-during-write: a lookup at the index being written in the same cycle returns the OLD contents; there is no bypass.
- mispredict (combinational, same cycle as rs_*), asserted when rs_valid and either:
  - rs_is_branch and (rs_taken != rs_pred_taken, or rs_taken and rs_target != rs_pred_target); or
  - !rs_is_branch and rs_pred_taken (aliased false hit).
- redirect_pc = (rs_is_branch and rs_taken) ? rs_target : rs_pc+4. It is driven whenever rs_valid, and is 0 otherwise.
- Update at the rising edge after rs_valid:
  - Branch, hit, taken: cnt = sat_inc(cnt); target = rs_target.
  - Branch, hit, not-taken: cnt = sat_dec(cnt); target unchanged.
  - Branch, miss, taken: allocate (overwrite) with valid=1, tag, target=rs_target, cnt=10.
  - Branch, miss, not-taken: no write.
  - Non-branch with a tag hit: valid cleared for that index.
  - Non-branch with no hit: no change.
- Saturation: inc at 11 stays 11; dec at 00 stays 00.
- Statistics: stat_branches increments on rs_valid and rs_is_branch; stat_mispredicts increments on mispredict. Both saturate at all-ones and never wrap.
- Reset (asynchronous, any time, including mid-update):
  - all valid=0, cnt=01, targets/tags=0, statistics=0;
  - pred_hit and pred_taken are 0 combinationally, because every valid bit is 0;
  - mispredict and redirect_pc are forced to 0 while rst=1;
  - no table write occurs on an edge where rst=1.
- Simultaneous lookup and update are independent; only one update per cycle.

Decomposition:
- Shared package/define file:
  - counter encodings SNT/WNT/WT/STR;
  - default ENTRIES and STAT_W;
  - PC increment constant 4.
- One sub-module, bp_sat_counter: 2-bit saturating inc/dec, purely combinational next-state function. It is instantiated once in the update path.

Test Plan:
1. Reset then lookup if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; stats=0.
2. Resolve a branch at pc=0x100 as taken to 0x80 with rs_pred_taken=0:
   - same cycle: mispredict=1, redirect_pc=0x80;
   - next cycle: lookup 0x100 gives pred_hit=1, pred_taken=1, pred_target=0x80, cnt=10.
3. Resolve 0x100 taken three more times -> cnt saturates at 11. Then one not-taken (rs_pred_taken=1) -> mispredict=1, redirect_pc=0x104, cnt=10, prediction still taken.
4. With ENTRIES=16, allocate pc=0x100, then resolve non-branch pc=0x100 with rs_pred_taken=1 -> mispredict=1, redirect_pc=0x104, entry invalidated. Separately, branch at 0x140 (same index, different tag) taken -> replaces the entry; lookup 0x100 misses.
5. Same-cycle update and lookup of index of 0x100 -> lookup returns pre-update values; the following cycle returns updated values.
6. Assert rst asynchronously mid-cycle with rs_valid=1 -> mispredict=0 immediately, table and statistics cleared. Separately, force stat_mispredicts to all-ones -> stays all-ones after a further mispredict.
